dma_xfer_engine: RTL and testbench

- Transfer engine behind the DMA control/address register block; consumes its programmed source address, destination address, count and control fields.
- Drives the DMA master bus port (bus_req/bus_lock/addr_m/we_m/wd_m/byte_en) to copy data memory-to-memory as read-then-write beats.
- Optionally paces each beat on the peripheral dma_req line.
- Reports busy/done back to the register block.

---
 rtl/dma_xfer_engine.sv | 199 +++++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_engine.sv
// rtl/dma_xfer_engine.sv - memory-to-memory DMA transfer engine
//
// Purpose: copies xfer_cnt beats from src_addr to dst_addr over the DMA
// master port, one read beat followed by one write beat per element,
// optionally paced by the peripheral dma_req line.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   start, abort                   launch pulse / terminate request
//   src_addr, dst_addr, xfer_cnt   programmed transfer descriptor
//   size, src_inc, dst_inc         beat size and address stepping
//   req_mode, dma_req              per-beat pacing enable / request
//   bus_req, bus_lock, bus_grant   master bus arbitration
//   addr_m, we_m, wd_m, byte_en    master bus command
//   rd_m                           master read data (one cycle after RD)
//   busy, done                     status back to the register block
module dma_xfer_engine #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] xfer_cnt,
  input  logic [1:0]       size,
  input  logic             src_inc,
  input  logic             dst_inc,
  input  logic             req_mode,
  input  logic             dma_req,
  output logic             bus_req,
  output logic             bus_lock,
  input  logic             bus_grant,
  output logic [31:0]      addr_m,
  output logic             we_m,
  output logic [31:0]      wd_m,
  output logic [3:0]       byte_en,
  input  logic [31:0]      rd_m,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REQ, S_REQ_BUS, S_RD, S_CAP, S_WR, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q, addr_hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q;
  logic             src_inc_q, dst_inc_q, req_mode_q;

  logic             launch;
  logic             beat_done;
  logic [31:0]      inc_amt;

  // Lanes touched by an element of the given size at the given address.
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_mask = 4'b0001 << a;
      2'd1:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Pull the element out of its source lane and replicate it so that the
  // write side finds it on whatever lane the destination address selects.
  function automatic logic [31:0] realign(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'd0:    realign = {4{b}};
      2'd1:    realign = {2{h}};
      default: realign = word;
    endcase
  endfunction

  assign launch    = (state_q == S_IDLE) && start && !abort;
  assign beat_done = (state_q == S_WR) && bus_grant;
  assign inc_amt   = (size_q == 2'd0) ? 32'd1 : (size_q == 2'd1) ? 32'd2 : 32'd4;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (xfer_cnt == '0)  state_d = S_DONE;
          else if (req_mode)   state_d = S_WAIT_REQ;
          else                 state_d = S_REQ_BUS;
        end
      end
      S_WAIT_REQ: if (dma_req)   state_d = S_REQ_BUS;
      S_REQ_BUS:  if (bus_grant) state_d = S_RD;
      S_RD:       if (bus_grant) state_d = S_CAP;
      S_CAP:                     state_d = S_WR;
      S_WR: begin
        if (bus_grant) begin
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
          else if (req_mode_q)    state_d = S_WAIT_REQ;
          else                    state_d = S_REQ_BUS;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output logic
  always_comb begin
    bus_req  = 1'b0;
    bus_lock = 1'b0;
    we_m     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    addr_m   = addr_hold_q;
    byte_en  = 4'b0000;
    case (state_q)
      S_IDLE:     busy = 1'b0;
      S_WAIT_REQ: busy = 1'b1;
      S_REQ_BUS:  bus_req = 1'b1;
      S_RD: begin
        bus_req  = 1'b1;
        bus_lock = 1'b1;
        addr_m   = src_q;
        byte_en  = lane_mask(src_q[1:0], size_q);
      end
      S_CAP: begin
        bus_req  = 1'b1;
        bus_lock = 1'b1;
      end
      S_WR: begin
        bus_req  = 1'b1;
        bus_lock = 1'b1;
        addr_m   = dst_q;
        byte_en  = lane_mask(dst_q[1:0], size_q);
        // A stalled write keeps its address and lanes but must not strobe.
        we_m     = bus_grant;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign wd_m = data_q;

  // Descriptor latches, beat counter and data path
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      req_mode_q  <= 1'b0;
      data_q      <= '0;
      addr_hold_q <= '0;
    end else begin
      if (launch) begin
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        cnt_q      <= xfer_cnt;
        size_q     <= size;
        src_inc_q  <= src_inc;
        dst_inc_q  <= dst_inc;
        req_mode_q <= req_mode;
      end
      if (state_q == S_CAP) begin
        data_q <= realign(rd_m, src_q[1:0], size_q);
      end
      if (state_q == S_RD) addr_hold_q <= src_q;
      if (state_q == S_WR) addr_hold_q <= dst_q;
      if (beat_done) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (src_inc_q) src_q <= src_q + inc_amt;
        if (dst_inc_q) dst_q <= dst_q + inc_amt;
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// tb/tb_dma_xfer_engine.sv - self-checking bench for dma_xfer_engine
module tb_dma_xfer_engine;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] xfer_cnt = '0;
  logic [1:0]  size = '0;
  logic        src_inc = 1'b0, dst_inc = 1'b0, req_mode = 1'b0;
  logic        dma_req = 1'b0, bus_grant = 1'b0;
  logic [31:0] rd_m = '0;
  logic        bus_req, bus_lock, we_m, busy, done;
  logic [31:0] addr_m, wd_m;
  logic [3:0]  byte_en;

  dma_xfer_engine #(.CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .xfer_cnt(xfer_cnt), .size(size),
    .src_inc(src_inc), .dst_inc(dst_inc), .req_mode(req_mode), .dma_req(dma_req),
    .bus_req(bus_req), .bus_lock(bus_lock), .bus_grant(bus_grant),
    .addr_m(addr_m), .we_m(we_m), .wd_m(wd_m), .byte_en(byte_en),
    .rd_m(rd_m), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          cyc;
  } beat_t;

  typedef struct {
    logic [31:0] src, dst;
    logic [1:0]  sz;
    logic [31:0] rd;
    logic [3:0]  rbe, wbe;
    logic [31:0] wd;
  } vec_t;

  beat_t got_rd[$], got_wr[$], exp_rd[$], exp_wr[$];
  int    tests = 0, fails = 0;
  int    cyc = 0, done_cnt = 0, done_cyc = 0, done_busy_viol = 0;
  bit    rnd_en = 1'b0, fixed_en = 1'b0;
  logic [31:0] fixed_rd = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Memory slave: data for the address presented in a read cycle appears next cycle.
  always @(posedge clk)
    if (bus_lock && !we_m && byte_en != 4'b0000)
      rd_m <= fixed_en ? fixed_rd : mem_word(addr_m);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample the bus at the falling edge, then advance past the next rising edge.
  task automatic step();
    @(negedge clk);
    if (bus_grant && bus_lock && !we_m && byte_en != 4'b0000)
      got_rd.push_back(beat_t'{addr_m, byte_en, 32'h0, cyc});
    if (we_m) got_wr.push_back(beat_t'{addr_m, byte_en, wd_m, cyc});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) done_busy_viol++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rnd_en) begin
      bus_grant = ($urandom_range(0, 3) != 0);
      dma_req   = $urandom_range(0, 1) == 1;
    end
  endtask

  // Expected bus traffic for a transfer, built element by element.
  task automatic model(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                       input logic [1:0] sz, input bit si, input bit di);
    int          w, sl, dl;
    logic [31:0] sa, da, word, elem;
    w = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < cnt; i++) begin
      sa   = src + (si ? 32'(i * w) : 32'd0);
      da   = dst + (di ? 32'(i * w) : 32'd0);
      sl   = (int'(sa % 4) / w) * w;
      dl   = (int'(da % 4) / w) * w;
      word = fixed_en ? fixed_rd : mem_word(sa);
      if (w == 4) elem = word;
      else        elem = (word >> (8 * sl)) & ((32'd1 << (8 * w)) - 32'd1);
      if (w == 1)      elem = elem * 32'h01010101;
      else if (w == 2) elem = elem * 32'h00010001;
      exp_rd.push_back(beat_t'{sa, 4'(((1 << w) - 1) << sl), 32'h0, 0});
      exp_wr.push_back(beat_t'{da, 4'(((1 << w) - 1) << dl), elem, 0});
    end
  endtask

  task automatic launch(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                        input logic [1:0] sz, input bit si, input bit di, input bit rm);
    got_rd.delete(); got_wr.delete(); exp_rd.delete(); exp_wr.delete();
    model(src, dst, cnt, sz, si, di);
    src_addr = src; dst_addr = dst; xfer_cnt = 16'(cnt); size = sz;
    src_inc = si; dst_inc = di; req_mode = rm;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) step();
    chk({name, " done"}, done_cnt - d0, 1);
  endtask

  task automatic check_xfer(input string name);
    chk({name, " nrd"}, got_rd.size(), exp_rd.size());
    chk({name, " nwr"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
      chk($sformatf("%s rd%0d", name, i), {got_rd[i].addr, got_rd[i].be},
          {exp_rd[i].addr, exp_rd[i].be});
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      chk($sformatf("%s wa%0d", name, i), {got_wr[i].addr, got_wr[i].be},
          {exp_wr[i].addr, exp_wr[i].be});
      chk($sformatf("%s wd%0d", name, i), got_wr[i].data, exp_wr[i].data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v[7];
    int   d0, caps;
    bit   saw_req, saw_busy;
    logic [31:0] s, d;

    v[0] = '{32'h101, 32'h203, 2'd0, 32'hAABBCCDD, 4'b0010, 4'b1000, 32'hCCCCCCCC};
    v[1] = '{32'h102, 32'h200, 2'd1, 32'hAABBCCDD, 4'b1100, 4'b0011, 32'hAABBAABB};
    v[2] = '{32'h103, 32'h201, 2'd1, 32'hAABBCCDD, 4'b1100, 4'b0011, 32'hAABBAABB};
    v[3] = '{32'h106, 32'h20B, 2'd2, 32'h12345678, 4'b1111, 4'b1111, 32'h12345678};
    v[4] = '{32'h100, 32'h300, 2'd3, 32'hCAFEF00D, 4'b1111, 4'b1111, 32'hCAFEF00D};
    v[5] = '{32'h103, 32'h200, 2'd0, 32'h11223344, 4'b1000, 4'b0001, 32'h11111111};
    v[6] = '{32'h100, 32'h202, 2'd1, 32'h11223344, 4'b0011, 4'b1100, 32'h33443344};

    // Reset state
    #12;
    chk("reset ctrl", {bus_req, bus_lock, we_m, busy, done, byte_en}, 9'h0);
    chk("reset addr/wd", {addr_m, wd_m}, 64'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    bus_grant = 1'b1;
    step();

    // Word copy with timing
    launch(32'h100, 32'h200, 4, 2'd2, 1, 1, 0);
    wait_done("word", 100);
    check_xfer("word");
    for (int i = 0; i < got_wr.size() && i < got_rd.size(); i++)
      chk($sformatf("word rd->wr gap%0d", i), got_wr[i].cyc - got_rd[i].cyc, 2);
    if (got_wr.size() > 0)
      chk("word done latency", done_cyc - got_wr[got_wr.size()-1].cyc, 1);

    // Lane/realignment vectors
    fixed_en = 1'b1;
    foreach (v[k]) begin
      fixed_rd = v[k].rd;
      launch(v[k].src, v[k].dst, 1, v[k].sz, 1, 1, 0);
      wait_done($sformatf("vec%0d", k), 50);
      chk($sformatf("vec%0d nrd", k), got_rd.size(), 1);
      chk($sformatf("vec%0d nwr", k), got_wr.size(), 1);
      if (got_rd.size() > 0)
        chk($sformatf("vec%0d rd", k), {got_rd[0].addr, got_rd[0].be}, {v[k].src, v[k].rbe});
      if (got_wr.size() > 0) begin
        chk($sformatf("vec%0d wr", k), {got_wr[0].addr, got_wr[0].be}, {v[k].dst, v[k].wbe});
        chk($sformatf("vec%0d wd", k), got_wr[0].data, v[k].wd);
      end
    end
    fixed_en = 1'b0;

    // Zero count
    d0 = done_cnt;
    saw_req = 1'b0; saw_busy = 1'b0;
    launch(32'h0, 32'h0, 0, 2'd2, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      saw_req  |= bus_req;
      saw_busy |= busy;
      step();
    end
    chk("zero done count", done_cnt - d0, 1);
    chk("zero bus_req", saw_req, 0);
    chk("zero busy", saw_busy, 0);

    // Pacing on dma_req, fixed source; a start while busy is ignored
    dma_req = 1'b0;
    launch(32'h400, 32'h500, 2, 2'd2, 0, 1, 1);
    for (int i = 0; i < 4; i++) step();
    chk("pace wait1", {bus_req, bus_lock, busy}, 3'b001);
    src_addr = 32'h999; xfer_cnt = 16'd7; start = 1'b1;
    step();
    start = 1'b0;
    dma_req = 1'b1;
    step();
    dma_req = 1'b0;
    for (int i = 0; i < 50 && got_wr.size() == 0; i++) step();
    chk("pace first wr", got_wr.size(), 1);
    for (int i = 0; i < 3; i++) step();
    chk("pace wait2", {bus_req, bus_lock, busy}, 3'b001);
    dma_req = 1'b1;
    step();
    dma_req = 1'b0;
    wait_done("pace", 50);
    check_xfer("pace");

    // Grant stall during WR
    launch(32'h600, 32'h700, 1, 2'd2, 1, 1, 0);
    for (int i = 0; i < 30 && !(bus_lock && byte_en == 4'b0000); i++) step();
    bus_grant = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      chk($sformatf("stall%0d", k), {we_m, byte_en, addr_m}, {1'b0, 4'hF, 32'h700});
    end
    chk("stall no write", got_wr.size(), 0);
    bus_grant = 1'b1;
    wait_done("stall", 30);
    check_xfer("stall");

    // Abort in CAP of beat 2
    d0 = done_cnt;
    caps = 0;
    launch(32'h800, 32'h900, 4, 2'd2, 1, 1, 0);
    for (int i = 0; i < 60 && caps < 2; i++) begin
      step();
      if (bus_lock && byte_en == 4'b0000) caps++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort outputs", {bus_req, bus_lock, we_m, byte_en, busy, done}, 9'h0);
    for (int i = 0; i < 5; i++) step();
    chk("abort no done", done_cnt - d0, 0);
    chk("abort writes", got_wr.size(), 1);

    // Abort and start together while idle
    d0 = done_cnt;
    saw_req = 1'b0; saw_busy = 1'b0;
    src_addr = 32'h100; xfer_cnt = 16'd3; req_mode = 1'b0;
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw_req  |= bus_req;
      saw_busy |= busy;
      step();
    end
    chk("abort+start busy/req", {saw_busy, saw_req}, 2'b00);
    chk("abort+start done", done_cnt - d0, 0);

    // Asynchronous reset mid-beat
    d0 = done_cnt;
    launch(32'h100, 32'h200, 4, 2'd2, 1, 1, 0);
    for (int i = 0; i < 30 && !we_m; i++) step();
    #2 rstn = 1'b0;
    #1;
    chk("rst mid ctrl", {bus_req, bus_lock, we_m, busy, done, byte_en}, 9'h0);
    chk("rst mid addr/wd", {addr_m, wd_m}, 64'h0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst mid idle", {busy, bus_req}, 2'b00);
    chk("rst mid no done", done_cnt - d0, 0);

    // Randomized transfers against the model
    rnd_en = 1'b1;
    for (int t = 0; t < 25; t++) begin
      s = $urandom;
      if (t % 4 == 0) s = 32'hFFFFFFF8 | ($urandom & 32'h7);
      d = (t % 5 == 0) ? (32'hFFFFFFF4 | ($urandom & 32'h3)) : $urandom;
      launch(s, d, $urandom_range(0, 6), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      wait_done($sformatf("rnd%0d", t), 600);
      check_xfer($sformatf("rnd%0d", t));
    end
    rnd_en = 1'b0;

    chk("done with busy", done_busy_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
